// File: rtl/fu_sequencer.sv
// Command/response sequencer for the 16-bit FunctionUnit, with a shift-add MUL macro-op.
// Optional: FU_SEQ_MUL_EARLY_EXIT_EN ends MUL once the remaining multiplier bits are all zero.
module fu_sequencer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MUL_ITERS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  output logic [3:0]       fu_fs,
  input  logic [WIDTH-1:0] fu_result,
  input  logic             fu_v,
  input  logic             fu_c,
  input  logic             fu_n,
  input  logic             fu_z
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  localparam int unsigned CW     = $clog2(MUL_ITERS + 1);
  localparam logic [4:0]  OP_MUL = 5'b10000;
  localparam logic [3:0]  FS_ADD = 4'b0010;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  // a_q/b_q double as multiplicand m and multiplier q during MUL
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] acc_nxt;
  logic             cs_nxt;
  logic             last_iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    res_d     = res_q;
    flags_d   = flags_q;
    err_d     = err_q;
    acc_nxt   = acc_q;
    cs_nxt    = cs_q;
    last_iter = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    fu_a      = '0;
    fu_b      = '0;
    fu_fs     = 4'b0000;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d = cmd_op[3:0];
          a_d  = cmd_a;
          b_d  = cmd_b;
          if (!cmd_op[4]) begin
            state_d = S_EXEC;
          end else if (cmd_op == OP_MUL) begin
            state_d = S_MUL;
            acc_d   = '0;
            cnt_d   = '0;
            cs_d    = 1'b0;
          end else begin
            state_d = S_RESP;
            res_d   = '0;
            flags_d = '0;
            err_d   = 1'b1;
          end
        end
      end

      S_EXEC: begin
        fu_a    = a_q;
        fu_b    = b_q;
        fu_fs   = op_q;
        res_d   = fu_result;
        flags_d = {fu_v, fu_c, fu_n, fu_z};
        err_d   = 1'b0;
        state_d = S_RESP;
      end

      S_MUL: begin
        fu_a  = acc_q;
        fu_b  = a_q;
        fu_fs = FS_ADD;
        if (b_q[0]) begin
          acc_nxt = fu_result;
          cs_nxt  = cs_q | fu_c;
        end
        acc_d = acc_nxt;
        cs_d  = cs_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        last_iter = (cnt_q == CW'(MUL_ITERS - 1));
`ifdef FU_SEQ_MUL_EARLY_EXIT_EN
        last_iter = last_iter || (b_d == '0);
`endif
        if (last_iter) begin
          res_d   = acc_nxt;
          flags_d = {1'b0, cs_nxt, acc_nxt[WIDTH-1], acc_nxt == '0};
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_fu_sequencer.sv
// Randomized self-checking bench for fu_sequencer: behavioural FU model plus a
// transaction-level sequencer reference checked every cycle.
module tb_fu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;
  logic [15:0] fu_a, fu_b, fu_result;
  logic [3:0]  fu_fs;
  logic        fu_v, fu_c, fu_n, fu_z;

  int errors = 0;
  int checks = 0;

  fu_sequencer #(.WIDTH(16), .MUL_ITERS(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy),
    .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_result(fu_result),
    .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z)
  );

  always #5 clk = ~clk;

  // FunctionUnit: {V,C,N,Z,F}
  function automatic logic [19:0] fu_eval(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] y, f;
    logic cin, v, c;
    y = '0; cin = 1'b0; v = 1'b0; c = 1'b0; f = '0;
    if (!fs[3]) begin
      case (fs[2:0])
        3'd1: cin = 1'b1;
        3'd2: y = b;
        3'd3: begin y = b; cin = 1'b1; end
        3'd4: y = ~b;
        3'd5: begin y = ~b; cin = 1'b1; end
        3'd6: y = '1;
        3'd7: begin y = '1; cin = 1'b1; end
        default: ;
      endcase
      s = {1'b0, a} + {1'b0, y} + {16'd0, cin};
      f = s[15:0];
      c = s[16];
      v = (a[15] == y[15]) && (f[15] != a[15]);
    end else begin
      case (fs[2:0])
        3'd0: f = a & b;
        3'd1: f = a | b;
        3'd2: f = a ^ b;
        3'd3: f = ~a;
        3'd4: f = b;
        3'd5: f = b >> 1;
        3'd6: f = b << 1;
        default: f = ~b;
      endcase
    end
    return {v, c, f[15], f == 16'd0, f};
  endfunction

  always_comb {fu_v, fu_c, fu_n, fu_z, fu_result} = fu_eval(fu_fs, fu_a, fu_b);

  // Partial product after k multiplier bits: {sticky carry, acc}
  function automatic logic [16:0] mul_partial(input logic [15:0] a, input logic [15:0] b, input int k);
    logic [16:0] s;
    logic [15:0] acc;
    logic cs;
    acc = '0; cs = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (b[i]) begin
        s   = {1'b0, acc} + {1'b0, 16'(a << i)};
        acc = s[15:0];
        cs  = cs | s[16];
      end
    end
    return {cs, acc};
  endfunction

  function automatic int mul_iters(input logic [15:0] b);
    int n;
    n = 16;
`ifdef FU_SEQ_MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
`endif
    return n;
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [15:0] b);
    if (!op[4]) return 2;
    if (op == 5'b10000) return mul_iters(b) + 1;
    return 1;
  endfunction

  // {err, flags, result}
  function automatic logic [20:0] exp_rsp(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [19:0] r;
    logic [16:0] p;
    if (!op[4]) begin
      r = fu_eval(op[3:0], a, b);
      return {1'b0, r};
    end
    if (op == 5'b10000) begin
      p = mul_partial(a, b, 16);
      return {1'b0, 1'b0, p[16], p[15], p[15:0] == 16'd0, p[15:0]};
    end
    return {1'b1, 20'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: accept, wait the latency, hold response until handshake
  logic        m_busy = 1'b0;
  int          m_since = 0;
  int          m_lat = 0;
  logic [4:0]  m_op = '0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [20:0] m_rsp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_since <= 0;
    end else if (m_busy) begin
      if (m_since >= m_lat && rsp_ready) m_busy <= 1'b0;
      else m_since <= m_since + 1;
    end else if (cmd_valid) begin
      m_busy  <= 1'b1;
      m_since <= 1;
      m_lat   <= exp_lat(cmd_op, cmd_b);
      m_op    <= cmd_op;
      m_a     <= cmd_a;
      m_b     <= cmd_b;
      m_rsp   <= exp_rsp(cmd_op, cmd_a, cmd_b);
    end
  end

  always @(negedge clk) begin
    logic        rv;
    logic [16:0] p;
    rv = m_busy && (m_since >= m_lat);
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(rv));
    if (rv) begin
      chk("rsp_result", 32'(rsp_result), 32'(m_rsp[15:0]));
      chk("rsp_flags", 32'(rsp_flags), 32'(m_rsp[19:16]));
      chk("rsp_err", 32'(rsp_err), 32'(m_rsp[20]));
    end
    if (m_busy && !m_op[4] && m_since == 1) begin
      chk("exec_fu_a", 32'(fu_a), 32'(m_a));
      chk("exec_fu_b", 32'(fu_b), 32'(m_b));
      chk("exec_fu_fs", 32'(fu_fs), 32'(m_op[3:0]));
    end else if (m_busy && m_op == 5'b10000 && m_since < m_lat) begin
      p = mul_partial(m_a, m_b, m_since - 1);
      chk("mul_fu_a", 32'(fu_a), 32'(p[15:0]));
      chk("mul_fu_b", 32'(fu_b), 32'(16'(m_a << (m_since - 1))));
      chk("mul_fu_fs", 32'(fu_fs), 32'h2);
    end else begin
      chk("quiet_fu_a", 32'(fu_a), 32'h0);
      chk("quiet_fu_b", 32'(fu_b), 32'h0);
      chk("quiet_fu_fs", 32'(fu_fs), 32'h0);
    end
  end

  // Issue one command, measure cycles from accept to rsp_valid, then handshake after hold cycles
  task automatic do_cmd(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] r, output logic [3:0] f, output logic e, output int lat);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL accept_timeout: cmd_ready never rose");
    end
    @(posedge clk); #1;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 5'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    cmd_valid = 1'b0;
    if (lat >= 100) begin
      errors++; checks++;
      $display("FAIL rsp_timeout: rsp_valid never rose");
    end
    r = rsp_result; f = rsp_flags; e = rsp_err;
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    logic        e;
    int          lat;
    logic [4:0]  op;
    logic [15:0] a, b;
    int          sel;
    int          ee;
`ifdef FU_SEQ_MUL_EARLY_EXIT_EN
    ee = 1;
`else
    ee = 0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_result", 32'(rsp_result), 32'h0);
    chk("rst_flags", 32'(rsp_flags), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fu_a", 32'(fu_a), 32'h0);
    chk("rst_fu_fs", 32'(fu_fs), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_cmd(5'b00010, 16'h7FFF, 16'h0001, 0, r, f, e, lat);
    chk("add_result", 32'(r), 32'h8000);
    chk("add_flags", 32'(f), 32'b1010);
    chk("add_lat", 32'(lat), 32'd2);

    do_cmd(5'b00101, 16'h0005, 16'h0005, 5, r, f, e, lat);
    chk("sub_result", 32'(r), 32'h0000);
    chk("sub_flags", 32'(f), 32'b0101);
    chk("sub_lat", 32'(lat), 32'd2);

    do_cmd(5'b10000, 16'h0003, 16'h0005, 1, r, f, e, lat);
    chk("mul35_result", 32'(r), 32'h000F);
    chk("mul35_flags", 32'(f), 32'h0);
    chk("mul35_lat", 32'(lat), ee ? 32'd4 : 32'd17);

    do_cmd(5'b10000, 16'hFFFF, 16'h0002, 0, r, f, e, lat);
    chk("mulFx2_result", 32'(r), 32'hFFFE);
    chk("mulFx2_flags", 32'(f), 32'b0010);
    chk("mulFx2_lat", 32'(lat), ee ? 32'd3 : 32'd17);

    do_cmd(5'b10000, 16'hFFFF, 16'h0003, 0, r, f, e, lat);
    chk("mulFx3_result", 32'(r), 32'hFFFD);
    chk("mulFx3_flags", 32'(f), 32'b0110);

    do_cmd(5'b10000, 16'h1234, 16'h0000, 0, r, f, e, lat);
    chk("mulx0_result", 32'(r), 32'h0000);
    chk("mulx0_flags", 32'(f), 32'b0001);
    chk("mulx0_lat", 32'(lat), ee ? 32'd2 : 32'd17);

    do_cmd(5'b10011, 16'hABCD, 16'h1234, 2, r, f, e, lat);
    chk("ill_result", 32'(r), 32'h0);
    chk("ill_err", 32'(e), 32'h1);
    chk("ill_lat", 32'(lat), 32'd1);

    // Reset six cycles into a MUL
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 5'b10000; cmd_a = 16'h1234; cmd_b = 16'h0F0F;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midmul_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_fu_a", 32'(fu_a), 32'h0);
    chk("midrst_fu_b", 32'(fu_b), 32'h0);
    chk("midrst_fu_fs", 32'(fu_fs), 32'h0);
    chk("midrst_result", 32'(rsp_result), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(5'b00010, 16'h1234, 16'h0F0F, 0, r, f, e, lat);
    chk("postrst_result", 32'(r), 32'h2143);
    chk("postrst_flags", 32'(f), 32'h0);

    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      op = {1'b0, 4'($urandom)};
      else if (sel < 8) op = 5'b10000;
      else              op = 5'(5'b10001 + 5'($urandom_range(0, 14)));
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 16);
      do_cmd(op, a, b, $urandom_range(0, 3), r, f, e, lat);
      chk("rand_lat", 32'(lat), 32'(exp_lat(op, b)));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
